// File: rtl/tt_um_hoene_preamble_tx.sv
// Preamble transmitter: emits PULSE_COUNT clean rising edges to arm the downstream
// edge-counting selector, then forwards data_in on the same line until stop.
module tt_um_hoene_preamble_tx #(
  parameter int unsigned PULSE_COUNT = 63,
  parameter int unsigned HIGH_CYCLES = 2,
  parameter int unsigned LOW_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       data_in,
  output logic       out,
  output logic       busy,
  output logic       done,
  output logic [7:0] pulses_sent
);

  localparam int unsigned MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int unsigned PW         = $clog2(MAX_CYCLES + 1);
  localparam logic [PW-1:0] HI_LAST  = PW'(HIGH_CYCLES - 1);
  localparam logic [PW-1:0] LO_LAST  = PW'(LOW_CYCLES - 1);
  localparam logic [7:0]    PC_LAST  = 8'(PULSE_COUNT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRE_HIGH = 2'd1,
    PRE_LOW  = 2'd2,
    PASS     = 2'd3
  } state_t;

  state_t        state_q;
  logic [PW-1:0] phase_q;
  logic          out_q;
  logic          busy_q;
  logic          done_q;
  logic [7:0]    pulses_q;
  logic [7:0]    pulses_inc_s;

  assign pulses_inc_s = pulses_q + 8'd1;

  // Sequencer: stop overrides every transition, including the final pulse completing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pulses_q <= 8'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q  <= PRE_HIGH;
            phase_q  <= '0;
            out_q    <= 1'b1;
            busy_q   <= 1'b1;
            pulses_q <= 8'd0;
          end else begin
            out_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        PRE_HIGH: begin
          if (stop) begin
            state_q <= IDLE;
            phase_q <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (phase_q == HI_LAST) begin
            state_q <= PRE_LOW;
            phase_q <= '0;
            out_q   <= 1'b0;
          end else begin
            phase_q <= phase_q + {{(PW-1){1'b0}}, 1'b1};
          end
        end
        PRE_LOW: begin
          if (stop) begin
            state_q <= IDLE;
            phase_q <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (phase_q == LO_LAST) begin
            phase_q  <= '0;
            pulses_q <= pulses_inc_s;
            if (pulses_inc_s == PC_LAST) begin
              state_q <= PASS;
              out_q   <= data_in;
              done_q  <= 1'b1;
            end else begin
              state_q <= PRE_HIGH;
              out_q   <= 1'b1;
            end
          end else begin
            phase_q <= phase_q + {{(PW-1){1'b0}}, 1'b1};
          end
        end
        PASS: begin
          if (stop) begin
            state_q <= IDLE;
            phase_q <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            out_q <= data_in;
          end
        end
        default: begin
          state_q <= IDLE;
          phase_q <= '0;
          out_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out         = out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulses_sent = pulses_q;

endmodule

// File: tb/tb_tt_um_hoene_preamble_tx.sv
// Self-checking bench: default instance (63/2/2) and a short instance (3/1/1),
// expected line values queued as stimulus is applied and compared cycle by cycle.
module tb_tt_um_hoene_preamble_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, stop_a, data_a;
  logic       out_a, busy_a, done_a;
  logic [7:0] ps_a;
  logic       start_b, stop_b, data_b;
  logic       out_b, busy_b, done_b;
  logic [7:0] ps_b;

  int n_vec = 0;
  int n_err = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  tt_um_hoene_preamble_tx dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .data_in(data_a),
    .out(out_a), .busy(busy_a), .done(done_a), .pulses_sent(ps_a)
  );

  tt_um_hoene_preamble_tx #(.PULSE_COUNT(3), .HIGH_CYCLES(1), .LOW_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .data_in(data_b),
    .out(out_b), .busy(busy_b), .done(done_b), .pulses_sent(ps_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_out(input bit sel);
    return sel ? out_b : out_a;
  endfunction

  function automatic logic sel_done(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  // Called just after the edge that sampled start; walks the whole preamble.
  task automatic run_pre(input bit sel, input int pc, input int h, input int l);
    int   edges;
    logic prev, cur;
    for (int p = 0; p < pc; p++) begin
      for (int i = 0; i < h; i++) exp_q.push_back(1'b1);
      for (int i = 0; i < l; i++) exp_q.push_back(1'b0);
    end
    edges = 0;
    prev  = 1'b0;
    while (exp_q.size() > 0) begin
      cur = sel_out(sel);
      chk("pre_out", cur, exp_q.pop_front());
      chk("pre_no_done", sel_done(sel), 0);
      if (cur && !prev) edges++;
      prev = cur;
      tick();
    end
    chk("done_fires", sel_done(sel), 1);
    chk("pulses_final", sel ? ps_b : ps_a, pc);
    chk("edge_count", edges, pc);
  endtask

  task automatic check_idle_a(input string tag, input int ps);
    chk({tag, "_out"}, out_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_ps"}, ps_a, ps);
  endtask

  task automatic start_a_pulse();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  initial begin
    int done_cnt;
    rst_n = 1'b0;
    start_a = 1'b0; stop_a = 1'b0; data_a = 1'b0;
    start_b = 1'b0; stop_b = 1'b0; data_b = 1'b0;
    tick(); tick();
    check_idle_a("reset", 0);
    chk("reset_b_busy", busy_b, 0);
    rst_n = 1'b1;
    tick();

    // Short instance: 1,0,1,0,1,0 then pass-through; done exactly once.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    run_pre(1'b1, 3, 1, 1);
    done_cnt = 1;
    for (int i = 0; i < 6; i++) begin
      data_b = 1'(i % 2);
      exp_q.push_back(data_b);
      tick();
      chk("b_pass_out", out_b, exp_q.pop_front());
      if (done_b) done_cnt++;
    end
    chk("b_done_once", done_cnt, 1);
    stop_b = 1'b1;
    tick();
    stop_b = 1'b0;
    chk("b_stop_busy", busy_b, 0);

    // start and stop together in IDLE: stop wins.
    start_a = 1'b1; stop_a = 1'b1;
    tick();
    start_a = 1'b0; stop_a = 1'b0;
    check_idle_a("idle_collide", 0);

    // Full default preamble; first rising edge right after the start edge.
    start_a_pulse();
    chk("first_edge", out_a, 1);
    chk("busy_on_start", busy_a, 1);
    run_pre(1'b0, 63, 2, 2);

    // Pass-through with random data; start here has no effect.
    for (int i = 0; i < 20; i++) begin
      data_a  = 1'($urandom_range(0, 1));
      start_a = (i == 5) ? 1'b1 : 1'b0;
      exp_q.push_back(data_a);
      tick();
      chk("pass_out", out_a, exp_q.pop_front());
      chk("pass_busy", busy_a, 1);
      chk("pass_done", done_a, 0);
      chk("pass_ps", ps_a, 63);
    end
    start_a = 1'b0;
    data_a  = 1'b1;
    stop_a  = 1'b1;
    tick();
    stop_a = 1'b0;
    check_idle_a("stop_pass", 63);

    // Stop during the 10th pulse's high phase.
    start_a_pulse();
    for (int i = 0; i < 36; i++) tick();
    chk("p10_high", out_a, 1);
    chk("p10_ps", ps_a, 9);
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0;
    check_idle_a("stop_p10", 9);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stop_no_done", done_a, 0);
    end
    start_a_pulse();
    chk("restart_ps", ps_a, 0);
    run_pre(1'b0, 63, 2, 2);

    // Reset during PASS, then reset mid-preamble.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle_a("rst_pass", 0);
    start_a_pulse();
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle_a("rst_pre", 0);

    // Stop on the last low cycle of the final pulse: no done, count not bumped.
    start_a_pulse();
    for (int i = 0; i < 251; i++) begin
      chk("col_no_done", done_a, 0);
      tick();
    end
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0;
    check_idle_a("collide_last", 62);

    // start held high across a stop re-arms on the first IDLE cycle.
    start_a = 1'b1; stop_a = 1'b1;
    tick();
    check_idle_a("held_stop", 62);
    stop_a = 1'b0;
    tick();
    chk("rearm_out", out_a, 1);
    chk("rearm_ps", ps_a, 0);
    start_a = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
